// File: rtl/axi_mem_pkg.sv
// Shared AXI4 channel structs, burst/response encodings and FSM state types
// for the axi_mem slave and its storage array.
package axi_mem_pkg;

  localparam int unsigned AXI_ADDR_W         = 32;
  localparam int unsigned AXI_DATA_W         = 32;
  localparam int unsigned AXI_ID_W           = 4;
  localparam int unsigned AXI_BYTES_PER_WORD = AXI_DATA_W / 8;

  typedef logic [7:0] axi_len_t;
  typedef logic [2:0] axi_size_t;
  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t OKAY   = 2'b00;
  localparam axi_resp_t SLVERR = 2'b10;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} axi_wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} axi_rd_state_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]           awid;
    logic [AXI_ADDR_W-1:0]         awaddr;
    axi_len_t                      awlen;
    axi_size_t                     awsize;
    axi_burst_t                    awburst;
    logic                          awvalid;
    logic [AXI_DATA_W-1:0]         wdata;
    logic [AXI_BYTES_PER_WORD-1:0] wstrb;
    logic                          wlast;
    logic                          wvalid;
    logic                          bready;
    logic [AXI_ID_W-1:0]           arid;
    logic [AXI_ADDR_W-1:0]         araddr;
    axi_len_t                      arlen;
    axi_size_t                     arsize;
    axi_burst_t                    arburst;
    logic                          arvalid;
    logic                          rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    axi_resp_t             bresp;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    axi_resp_t             rresp;
    logic                  rlast;
    logic                  rvalid;
  } s_axi_miso_t;

  // WRAP and the reserved encoding are both rejected.
  function automatic logic axi_burst_ok(input axi_burst_t burst);
    return (burst == FIXED) || (burst == INCR);
  endfunction

  function automatic logic [AXI_ADDR_W-1:0] axi_next_addr(
    input logic [AXI_ADDR_W-1:0] addr,
    input axi_size_t             size,
    input axi_burst_t            burst
  );
    return (burst == INCR) ? addr + (AXI_ADDR_W'(1) << size) : addr;
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// 1W/1R synchronous SRAM with byte-enable writes; a read in the same cycle
// as a write to the same word returns the old contents.
module axi_mem_array #(
  parameter  int unsigned WORDS  = 1024,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned IDX_W  = $clog2(WORDS),
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [BE_W-1:0]   i_wr_be,
  input  logic              i_rd_en,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [WORDS];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_idx];
    end
    if (i_wr_en) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (i_wr_be[b]) begin
          r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axi_mem.sv
// AXI4 slave RAM: independent write and read FSMs, FIXED/INCR bursts,
// per-beat range checking, one outstanding transaction per direction.
module axi_mem
  import axi_mem_pkg::*;
#(
  parameter int unsigned           MEM_KB       = 4,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR    = 32'h8000_0000,
  parameter bit                    ID_WIDTH_CHK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  s_axi_mosi_t axi_mosi_i,
  output s_axi_miso_t axi_miso_o
);

  localparam int unsigned MEM_BYTES  = MEM_KB * 1024;
  localparam int unsigned WORDS      = MEM_BYTES / AXI_BYTES_PER_WORD;
  localparam int unsigned IDX_W      = $clog2(WORDS);
  localparam int unsigned ADDR_SHIFT = $clog2(AXI_BYTES_PER_WORD);

  // Addresses below BASE_ADDR wrap to a large offset and fail the compare.
  function automatic logic in_range(input logic [AXI_ADDR_W-1:0] addr);
    return (addr - BASE_ADDR) < AXI_ADDR_W'(MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_W-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> ADDR_SHIFT);
  endfunction

  axi_wr_state_t         r_wstate, w_wstate_nxt;
  axi_rd_state_t         r_rstate, w_rstate_nxt;

  logic [AXI_ID_W-1:0]   r_awid;
  logic [AXI_ADDR_W-1:0] r_awaddr;
  axi_len_t              r_awlen;
  axi_size_t             r_awsize;
  axi_burst_t            r_awburst;
  axi_len_t              r_wbeat;
  logic                  r_bresp_err;

  logic [AXI_ID_W-1:0]   r_arid;
  logic [AXI_ADDR_W-1:0] r_araddr;
  axi_len_t              r_arlen;
  axi_size_t             r_arsize;
  axi_burst_t            r_arburst;
  axi_len_t              r_rbeat;
  logic [AXI_DATA_W-1:0] r_rdata;
  axi_resp_t             r_rresp;
  logic                  r_rlast;

  logic                  w_w_hs, w_wr_err, w_wbeat_last, w_wr_en;
  logic                  w_rd_err, w_rd_en;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [AXI_ADDR_W-1:0] w_rd_next_addr;
  logic [AXI_DATA_W-1:0] w_arr_rdata;

  assign w_wr_err       = !in_range(r_awaddr) || !axi_burst_ok(r_awburst);
  assign w_wbeat_last   = (r_wbeat == r_awlen);
  assign w_w_hs         = (r_wstate == W_DATA) && axi_mosi_i.wvalid;
  assign w_rd_err       = !in_range(r_araddr) || !axi_burst_ok(r_arburst);
  assign w_rd_next_addr = axi_next_addr(r_araddr, r_arsize, r_arburst);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wr_en      = 1'b0;
    unique case (r_wstate)
      W_IDLE: if (axi_mosi_i.awvalid) w_wstate_nxt = W_DATA;
      W_DATA: begin
        w_wr_en = w_w_hs && !w_wr_err;
        if (w_w_hs && (axi_mosi_i.wlast || w_wbeat_last)) w_wstate_nxt = W_RESP;
      end
      W_RESP: if (axi_mosi_i.bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // The next beat's read is issued on the R handshake itself, so R_FETCH
  // always sees array data for the address now held in r_araddr.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rd_en      = 1'b0;
    w_rd_idx     = word_idx(axi_mosi_i.araddr);
    unique case (r_rstate)
      R_IDLE: begin
        if (axi_mosi_i.arvalid) begin
          w_rd_en      = 1'b1;
          w_rstate_nxt = R_FETCH;
        end
      end
      R_FETCH: w_rstate_nxt = R_DATA;
      R_DATA: begin
        if (axi_mosi_i.rready) begin
          if (r_rlast) begin
            w_rstate_nxt = R_IDLE;
          end else begin
            w_rd_en      = 1'b1;
            w_rd_idx     = word_idx(w_rd_next_addr);
            w_rstate_nxt = R_FETCH;
          end
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_awid      <= '0;
      r_awaddr    <= '0;
      r_awlen     <= '0;
      r_awsize    <= '0;
      r_awburst   <= FIXED;
      r_wbeat     <= '0;
      r_bresp_err <= 1'b0;
    end else begin
      if ((r_wstate == W_IDLE) && axi_mosi_i.awvalid) begin
        r_awid      <= axi_mosi_i.awid;
        r_awaddr    <= axi_mosi_i.awaddr;
        r_awlen     <= axi_mosi_i.awlen;
        r_awsize    <= axi_mosi_i.awsize;
        r_awburst   <= axi_mosi_i.awburst;
        r_wbeat     <= '0;
        r_bresp_err <= 1'b0;
      end
      if (w_w_hs) begin
        r_awaddr <= axi_next_addr(r_awaddr, r_awsize, r_awburst);
        r_wbeat  <= r_wbeat + 8'd1;
        if (w_wr_err || (axi_mosi_i.wlast != w_wbeat_last)) r_bresp_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= FIXED;
      r_rbeat   <= '0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
      r_rlast   <= 1'b0;
    end else begin
      if ((r_rstate == R_IDLE) && axi_mosi_i.arvalid) begin
        r_arid    <= axi_mosi_i.arid;
        r_araddr  <= axi_mosi_i.araddr;
        r_arlen   <= axi_mosi_i.arlen;
        r_arsize  <= axi_mosi_i.arsize;
        r_arburst <= axi_mosi_i.arburst;
        r_rbeat   <= '0;
      end
      if (r_rstate == R_FETCH) begin
        r_rdata <= w_rd_err ? '0 : w_arr_rdata;
        r_rresp <= w_rd_err ? SLVERR : OKAY;
        r_rlast <= (r_rbeat == r_arlen);
      end
      if ((r_rstate == R_DATA) && axi_mosi_i.rready && !r_rlast) begin
        r_araddr <= w_rd_next_addr;
        r_rbeat  <= r_rbeat + 8'd1;
      end
    end
  end

  axi_mem_array #(
    .WORDS  (WORDS),
    .DATA_W (AXI_DATA_W)
  ) u_array (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (word_idx(r_awaddr)),
    .i_wr_data (axi_mosi_i.wdata),
    .i_wr_be   (axi_mosi_i.wstrb),
    .i_rd_en   (w_rd_en),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_arr_rdata)
  );

  // Ready flags are gated by rst so every output reads 0 while in reset.
  always_comb begin
    axi_miso_o         = '0;
    axi_miso_o.awready = rst && (r_wstate == W_IDLE);
    axi_miso_o.wready  = (r_wstate == W_DATA);
    axi_miso_o.bvalid  = (r_wstate == W_RESP);
    axi_miso_o.bresp   = r_bresp_err ? SLVERR : OKAY;
    axi_miso_o.bid     = ID_WIDTH_CHK ? r_awid : '0;
    axi_miso_o.arready = rst && (r_rstate == R_IDLE);
    axi_miso_o.rvalid  = (r_rstate == R_DATA);
    axi_miso_o.rdata   = r_rdata;
    axi_miso_o.rresp   = r_rresp;
    axi_miso_o.rlast   = r_rlast;
    axi_miso_o.rid     = ID_WIDTH_CHK ? r_arid : '0;
  end

endmodule
